// File: rtl/burst_line_adapter.sv
// Cache-line to BurstRAM adapter: serialises line writes into beat bursts and
// gathers read beats into a line, with a timeout for reads that never return.
module burst_line_adapter #(
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4,
  parameter int unsigned DEPTH_BITWIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            req_valid,
  output logic                                            req_ready,
  input  logic                                            req_write,
  input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]   req_line,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]            req_wr_line,
  output logic                                            rsp_valid,
  output logic                                            rsp_error,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]            rsp_rd_line,
  output logic                                            br_cmd,
  output logic                                            br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]                       br_addr,
  output logic [DATA_BITWIDTH-1:0]                        br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                      br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]                        br_rd_data,
  input  logic                                            br_rd_data_valid,
  input  logic                                            br_busy
);

  localparam int unsigned BEAT_W    = $clog2(BURST_COUNT);
  localparam int unsigned CNT_W     = (BEAT_W > 0) ? BEAT_W : 1;
  localparam int unsigned LINE_BITS = DATA_BITWIDTH * BURST_COUNT;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WR_BEATS, RD_WAIT, RESP} state_e;

  state_e                      state_q,       state_d;
  logic [CNT_W-1:0]            beat_cnt_q,    beat_cnt_d;
  logic [TMO_W-1:0]            tmo_cnt_q,     tmo_cnt_d;
  logic [LINE_BITS-1:0]        wr_line_q,     wr_line_d;
  logic                        br_cmd_q,      br_cmd_d;
  logic                        br_cmd_en_q,   br_cmd_en_d;
  logic [DEPTH_BITWIDTH-1:0]   br_addr_q,     br_addr_d;
  logic [DATA_BITWIDTH-1:0]    br_wr_data_q,  br_wr_data_d;
  logic                        rsp_valid_q,   rsp_valid_d;
  logic                        rsp_error_q,   rsp_error_d;
  logic [LINE_BITS-1:0]        rsp_rd_line_q, rsp_rd_line_d;

  assign req_ready    = !rst && (state_q == IDLE) && !br_busy;
  assign br_cmd       = br_cmd_q;
  assign br_cmd_en    = br_cmd_en_q;
  assign br_addr      = br_addr_q;
  assign br_wr_data   = br_wr_data_q;
  assign br_data_mask = '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_rd_line  = rsp_rd_line_q;

  // Next-state and registered-output values; strobes default low each cycle.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    wr_line_d     = wr_line_q;
    br_cmd_d      = br_cmd_q;
    br_cmd_en_d   = 1'b0;
    br_addr_d     = br_addr_q;
    br_wr_data_d  = br_wr_data_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rd_line_d = rsp_rd_line_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          br_cmd_en_d = 1'b1;
          br_cmd_d    = req_write;
          br_addr_d   = DEPTH_BITWIDTH'(req_line) << BEAT_W;
          beat_cnt_d  = '0;
          tmo_cnt_d   = '0;
          if (req_write) begin
            wr_line_d    = req_wr_line;
            br_wr_data_d = req_wr_line[0 +: DATA_BITWIDTH];
            state_d      = WR_BEATS;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end

      // Beat beat_cnt_q is on the bus this cycle; load the following one.
      WR_BEATS: begin
        if (beat_cnt_q == LAST_BEAT) begin
          br_wr_data_d = '0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          beat_cnt_d   = beat_cnt_q + CNT_W'(1);
          br_wr_data_d = wr_line_q[(int'(beat_cnt_q) + 1) * DATA_BITWIDTH +: DATA_BITWIDTH];
        end
      end

      RD_WAIT: begin
        if (br_rd_data_valid) begin
          rsp_rd_line_d[int'(beat_cnt_q) * DATA_BITWIDTH +: DATA_BITWIDTH] = br_rd_data;
          tmo_cnt_d = '0;
          if (beat_cnt_q == LAST_BEAT) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      wr_line_q     <= '0;
      br_cmd_q      <= 1'b0;
      br_cmd_en_q   <= 1'b0;
      br_addr_q     <= '0;
      br_wr_data_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rd_line_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      wr_line_q     <= wr_line_d;
      br_cmd_q      <= br_cmd_d;
      br_cmd_en_q   <= br_cmd_en_d;
      br_addr_q     <= br_addr_d;
      br_wr_data_q  <= br_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rd_line_q <= rsp_rd_line_d;
    end
  end

endmodule
